// File: rtl/mat_pkg.sv
// Shared state encoding, byte counts and element addressing for the
// matrix operand loader and its result serializer.
package mat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } mat_state_e;

  localparam int MAT_OPERAND_BYTES = 8;
  localparam int MAT_RESULT_BYTES  = 4;

  // Bit offset of element [r][c] inside a packed 2x2 byte matrix.
  function automatic int elem_bit_offset(input int r, input int c);
    return 8 * (2 * r + c);
  endfunction

endpackage

// File: rtl/mat_operand_loader_if.sv
// Byte-in / operand / byte-out bus between the 8-bit core, the loader and
// the 2x2 matrix multiplier.
interface mat_operand_loader_if;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;

  logic [31:0] mm_a;
  logic [31:0] mm_b;
  logic        mm_start;
  logic [31:0] mm_c;
  logic        mm_done;

  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  // Loader side.
  modport slave (
    input  in_data, in_valid, mm_c, mm_done, out_ready,
    output in_ready, mm_a, mm_b, mm_start, out_data, out_valid
  );

  // Core / multiplier side.
  modport master (
    output in_data, in_valid, mm_c, mm_done, out_ready,
    input  in_ready, mm_a, mm_b, mm_start, out_data, out_valid
  );

endinterface

// File: rtl/mat_result_serializer.sv
// Captures a 32-bit product on a load pulse and emits it as four bytes,
// least significant first, over a valid/ready handshake.
module mat_result_serializer
  import mat_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] value,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        last_accept
);

  localparam logic [1:0] LAST_IDX = 2'(MAT_RESULT_BYTES - 1);

  logic [31:0] res_q, res_d;
  logic [1:0]  idx_q, idx_d;
  logic        vld_q, vld_d;
  logic        accept;
  logic [7:0]  res_bytes [MAT_RESULT_BYTES];

  assign accept      = vld_q && out_ready;
  assign last_accept = accept && (idx_q == LAST_IDX);

  for (genvar gi = 0; gi < MAT_RESULT_BYTES; gi++) begin : g_bytes
    assign res_bytes[gi] = res_q[gi*8 +: 8];
  end

  assign out_data  = res_bytes[idx_q];
  assign out_valid = vld_q;

  always_comb begin
    res_d = res_q;
    idx_d = idx_q;
    vld_d = vld_q;
    if (load) begin
      res_d = value;
      idx_d = '0;
      vld_d = 1'b1;
    end else if (accept) begin
      if (idx_q == LAST_IDX) begin
        vld_d = 1'b0;
        idx_d = '0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/mat_operand_loader.sv
// Collects eight operand bytes into two packed 2x2 matrices, starts the
// multiplier, then streams the 4-byte product back. Optional WAIT watchdog
// is built when MAT_LOADER_TIMEOUT_EN is defined.
module mat_operand_loader
  import mat_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mat_operand_loader_if.slave  io,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [2:0] LD_LAST = 3'(MAT_OPERAND_BYTES - 1);

  mat_state_e  state_q, state_d;
  logic [2:0]  ld_cnt_q, ld_cnt_d;
  logic        armed_q, armed_d;
  logic [7:0]  opnd_q [MAT_OPERAND_BYTES];
  logic [7:0]  opnd_d [MAT_OPERAND_BYTES];

  logic        in_xfer;
  logic        capture;
  logic        to_hit;
  logic        ser_load;
  logic        ser_last;

  assign io.in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign io.mm_start = (state_q == ST_START);
  assign busy        = (state_q != ST_IDLE);
  assign in_xfer     = io.in_valid && io.in_ready;
  assign capture     = (state_q == ST_WAIT) && armed_q && io.mm_done;

  // The load counter is zero whenever we sit in IDLE, so the first byte
  // lands in slot 0 without a separate IDLE write path.
  for (genvar gi = 0; gi < MAT_OPERAND_BYTES; gi++) begin : g_opnd
    assign opnd_d[gi] = (in_xfer && (ld_cnt_q == 3'(gi))) ? io.in_data : opnd_q[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        opnd_q[gi] <= '0;
      end else begin
        opnd_q[gi] <= opnd_d[gi];
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_pack
    assign io.mm_a[elem_bit_offset(gi / 2, gi % 2) +: 8] = opnd_q[gi];
    assign io.mm_b[elem_bit_offset(gi / 2, gi % 2) +: 8] = opnd_q[gi + 4];
  end

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    armed_d  = armed_q;
    ser_load = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (in_xfer) begin
          if (ld_cnt_q == LD_LAST) begin
            ld_cnt_d = '0;
            state_d  = ST_START;
          end else begin
            ld_cnt_d = ld_cnt_q + 3'd1;
            state_d  = ST_LOAD;
          end
        end
      end
      ST_START: begin
        armed_d = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done level left over from the previous operation must fall
        // before a rising done can be trusted.
        if (capture) begin
          ser_load = 1'b1;
          armed_d  = 1'b0;
          state_d  = ST_DRAIN;
        end else if (to_hit) begin
          armed_d  = 1'b0;
          state_d  = ST_IDLE;
        end else if (!io.mm_done) begin
          armed_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (ser_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ld_cnt_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      armed_q  <= armed_d;
    end
  end

`ifdef MAT_LOADER_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;

  // to_cnt_q holds the number of WAIT cycles already completed.
  assign to_hit = (state_q == ST_WAIT) && (to_cnt_q == TO_LAST);

  always_comb begin
    to_cnt_d = '0;
    to_err_d = to_err_q;
    if (state_q == ST_WAIT) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    if (to_hit && !capture) begin
      to_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign to_hit             = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  mat_result_serializer u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ser_load),
    .value       (io.mm_c),
    .out_data    (io.out_data),
    .out_valid   (io.out_valid),
    .out_ready   (io.out_ready),
    .last_accept (ser_last)
  );

endmodule

// File: tb/tb_mat_operand_loader.sv
// Randomized self-checking bench for mat_operand_loader; expected operands and
// result bytes come from a byte-array model of the load/drain ordering.
module tb_mat_operand_loader;

  localparam int TO_CYCLES = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic timeout_err;

  int tests_run = 0;
  int tests_failed = 0;
  int start_pulses = 0;

  logic [31:0] exp_a;
  logic [31:0] exp_b;

  mat_operand_loader_if bus();

  mat_operand_loader #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io          (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mm_start === 1'b1) start_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1);
  end

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n >= 20) begin
      tests_failed++;
      $display("FAIL in_ready_wait: in_ready=%b expected 1 within 20 cycles", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Model: byte i goes to matrix A (i<4) or B, element index i%4 at bits 8*(i%4).
  task automatic load_op(input logic [7:0] b [8]);
    exp_a = '0;
    exp_b = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) exp_a[8*i +: 8] = b[i];
      else       exp_b[8*(i-4) +: 8] = b[i];
    end
    for (int i = 0; i < 8; i++) begin
      push_byte(b[i]);
      if (i < 7) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    tests_run++;
    if (bus.mm_start !== 1'b1 || bus.mm_a !== exp_a || bus.mm_b !== exp_b || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_state: mm_start=%b mm_a=%h mm_b=%h busy=%b expected 1 %h %h 1",
               bus.mm_start, bus.mm_a, bus.mm_b, busy, exp_a, exp_b);
    end
  endtask

  task automatic respond(input logic [31:0] c, input int stale_len, input int low_len, input bit hold_in);
    int n;
    if (hold_in) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
    end
    for (int k = 0; k < stale_len + low_len; k++) begin
      if (k == stale_len) bus.mm_done = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.mm_start !== 1'b0 || busy !== 1'b1 ||
          timeout_err !== 1'b0 || bus.mm_a !== exp_a || bus.mm_b !== exp_b) begin
        tests_failed++;
        $display("FAIL wait_state: in_ready=%b out_valid=%b mm_start=%b busy=%b timeout_err=%b mm_a=%h mm_b=%h expected 0 0 0 1 0 %h %h",
                 bus.in_ready, bus.out_valid, bus.mm_start, busy, timeout_err, bus.mm_a, bus.mm_b, exp_a, exp_b);
      end
    end
    if (stale_len + low_len == 0) bus.mm_done = 1'b0;
    bus.mm_c    = c;
    bus.mm_done = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.out_valid !== 1'b1 && n < 10);
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL capture: out_valid=%b expected 1 within 10 cycles of done rising", bus.out_valid);
    end
  endtask

  task automatic drain(input logic [31:0] c, input int stall [4]);
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      e = c[8*i +: 8];
      if (i == 3) bus.in_valid = 1'b0;
      for (int s = 0; s < stall[i]; s++) begin
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e || bus.in_ready !== 1'b0 ||
            bus.mm_a !== exp_a || bus.mm_b !== exp_b) begin
          tests_failed++;
          $display("FAIL drain_stall: byte %0d out_valid=%b out_data=%h in_ready=%b mm_a=%h expected 1 %h 0 %h",
                   i, bus.out_valid, bus.out_data, bus.in_ready, bus.mm_a, e, exp_a);
        end
        @(negedge clk);
      end
      bus.out_ready = 1'b1;
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
        tests_failed++;
        $display("FAIL drain_byte: byte %0d out_valid=%b out_data=%h expected 1 %h",
                 i, bus.out_valid, bus.out_data, e);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_end: out_valid=%b busy=%b in_ready=%b expected 0 0 1",
               bus.out_valid, busy, bus.in_ready);
    end
  endtask

  task automatic run_op(input logic [7:0] b [8], input logic [31:0] c, input int stale_len,
                        input int low_len, input bit hold_in, input int stall [4]);
    int pulses0;
    pulses0 = start_pulses;
    if (stale_len > 0) begin
      bus.mm_done = 1'b1;
      bus.mm_c    = ~c;
    end
    load_op(b);
    respond(c, stale_len, low_len, hold_in);
    drain(c, stall);
    tests_run++;
    if (start_pulses - pulses0 != 1) begin
      tests_failed++;
      $display("FAIL start_pulse_count: saw %0d mm_start cycles expected 1", start_pulses - pulses0);
    end
    $display("[TB] op a=%h b=%h c=%h stale=%0d low=%0d hold_in=%0d", exp_a, exp_b, c, stale_len, low_len, hold_in);
  endtask

  task automatic check_reset_values(input string tag);
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.mm_start !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.mm_a !== 32'h0 || bus.mm_b !== 32'h0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: in_ready=%b mm_start=%b out_valid=%b out_data=%h mm_a=%h mm_b=%h busy=%b timeout_err=%b expected 1 0 0 00 0 0 0 0",
               tag, bus.in_ready, bus.mm_start, bus.out_valid, bus.out_data, bus.mm_a, bus.mm_b, busy, timeout_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_basic();
    logic [7:0] b [8];
    int st [4];
    b  = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    st = '{0, 0, 0, 0};
    run_op(b, 32'h05040302, 0, 2, 1'b0, st);
    tests_run++;
    if (bus.mm_a !== 32'h01000001 || bus.mm_b !== 32'h05040302) begin
      tests_failed++;
      $display("FAIL basic_operands: mm_a=%h mm_b=%h expected 01000001 05040302", bus.mm_a, bus.mm_b);
    end
  endtask

  task automatic test_stale_done();
    logic [7:0] b [8];
    int st [4];
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    st = '{0, 1, 0, 0};
    run_op(b, 32'hAABBCCDD, 2, 2, 1'b0, st);
  endtask

  task automatic test_backpressure();
    logic [7:0] b [8];
    int st [4];
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    st = '{3, 0, 0, 0};
    run_op(b, 32'($urandom), 0, 3, 1'b0, st);
  endtask

  task automatic test_hold_in_valid();
    logic [7:0] b [8];
    int st [4];
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    st = '{1, 2, 1, 0};
    run_op(b, 32'($urandom), 0, 4, 1'b1, st);
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] b [8];
    int st [4];
    bus.mm_done = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(1, 255)));
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_load");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    st = '{0, 0, 1, 0};
    run_op(b, 32'($urandom), 0, 2, 1'b0, st);
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] b [8];
    bit seen;
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    load_op(b);
    respond(32'hDEADBEEF, 0, 2, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_drain");
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    bus.out_ready = 1'b0;
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL post_reset_output: out_valid seen=1 expected 0 after reset mid-drain");
    end
  endtask

  task automatic test_random();
    logic [7:0] b [8];
    int st [4];
    int stale;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) st[i] = int'($urandom_range(0, 2));
      stale = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(b, 32'($urandom), stale, int'($urandom_range(2, 5)), 1'($urandom_range(0, 1)), st);
    end
  endtask

`ifdef MAT_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] b [8];
    bit seen;
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    bus.mm_done = 1'b0;
    load_op(b);
    for (int k = 1; k < TO_CYCLES + 1; k++) begin
      @(negedge clk);
      tests_run++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL timeout_early: wait cycle %0d timeout_err=%b busy=%b expected 0 1", k, timeout_err, busy);
      end
    end
    @(negedge clk);
    tests_run++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_flag: timeout_err=%b busy=%b in_ready=%b expected 1 0 1", timeout_err, busy, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || timeout_err !== 1'b1) seen = 1'b1;
    end
    bus.out_ready = 1'b0;
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL timeout_after: out_valid or timeout_err changed, expected 0 and sticky 1");
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("timeout_reset_clear");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
`else
  task automatic test_wait_forever();
    logic [7:0] b [8];
    int st [4];
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    st = '{0, 0, 0, 0};
    run_op(b, 32'($urandom), 0, 40, 1'b0, st);
  endtask
`endif

  initial begin
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.mm_c      = 32'h0;
    bus.mm_done   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stale_done();
    test_backpressure();
    test_hold_in_valid();
    test_reset_mid_load();
    test_reset_mid_drain();
    test_random();
`ifdef MAT_LOADER_TIMEOUT_EN
    test_timeout();
`else
    test_wait_forever();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
